// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/RUN/DONE sequencer that owns the PC, presents
// the zero-latency instruction stream and counts RUN cycles for the program.
module instr_fetch #(
  parameter int unsigned PCW     = 10,
  parameter int unsigned IW      = 9,
  parameter logic [3:0]  HALT_OP = 4'b1011
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [PCW-1:0] start_addr,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic [IW-1:0]  instr,
  output logic [3:0]     opcode,
  output logic           instr_valid,
  input  logic           uncd_jmp,
  input  logic           jtype,
  input  logic           cond_taken,
  input  logic [PCW-1:0] jmp_target,
  output logic           done,
  output logic [15:0]    cycle_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [PCW-1:0] pc;
  logic           halt;
  logic           take_jump;

  assign imem_addr   = pc;
  assign instr       = imem_data;
  assign opcode      = imem_data[IW-1:IW-4];
  assign instr_valid = (state == RUN);
  assign halt        = (opcode == HALT_OP);
  assign take_jump   = jtype && (uncd_jmp || cond_taken);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= '0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            pc          <= start_addr;
            cycle_count <= '0;
            done        <= 1'b0;
          end
        end
        RUN: begin
          // The halt cycle is counted too; the count saturates rather than wraps.
          if (cycle_count != '1) cycle_count <= cycle_count + 16'd1;
          if (halt) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (take_jump) begin
            pc <= jmp_target;
          end else begin
            pc <= pc + PCW'(1);
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
